// File: rtl/hazard_pkg.sv
// Shared encodings and the shadow slot record for the hazard unit.
package hazard_pkg;

  localparam int SLOT_RW = 5;

  localparam logic [1:0] OPT_OTHER = 2'b00;
  localparam logic [1:0] OPT_ALU   = 2'b01;
  localparam logic [1:0] OPT_LOAD  = 2'b10;
  localparam logic [1:0] OPT_STORE = 2'b11;

  localparam logic [1:0] FWD_REG      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU   = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU  = 2'b10;
  localparam logic [1:0] FWD_MEM_LOAD = 2'b11;

  // Shadow copy of one pipeline slot; all-zero is a bubble.
  typedef struct packed {
    logic [SLOT_RW-1:0] rd;
    logic [1:0]         op;
    logic [SLOT_RW-1:0] rs2;
  } slot_t;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forward source select for one ID operand; EX beats MEM.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             rs_use,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [1:0]       ex_op,
  input  logic [REG_W-1:0] mem_rd,
  input  logic [1:0]       mem_op,
  output logic [1:0]       sel
);

  logic ex_hit, mem_hit;

  assign ex_hit  = (ex_rd  == rs) && (ex_rd  != '0);
  assign mem_hit = (mem_rd == rs) && (mem_rd != '0);

  // First match wins; an ALU in EX shadows any MEM producer.
  always_comb begin
    sel = FWD_REG;
    if (!rs_use)                            sel = FWD_REG;
    else if (ex_hit  && ex_op  == OPT_ALU)  sel = FWD_EX_ALU;
    else if (mem_hit && mem_op == OPT_ALU)  sel = FWD_MEM_ALU;
    else if (mem_hit && mem_op == OPT_LOAD) sel = FWD_MEM_LOAD;
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall, branch flush and forward selects for a 5-stage RV32I
// pipeline with branches resolved in ID. EX/MEM/WB are tracked as shadow
// records fed from the ID decoder's hazard interface.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] rs1_ID,
  input  logic [REG_W-1:0] rs2_ID,
  input  logic [REG_W-1:0] rd_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [1:0]       hazard_optype_ID,
  input  logic             Branch_ID,
  output logic             PC_EN_IF,
  output logic             reg_FD_EN,
  output logic             reg_FD_flush,
  output logic             reg_DE_flush,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls
);

  slot_t            ex_q, mem_q;
  logic [REG_W-1:0] wb_rd;
  logic [1:0]       wb_op;
  logic             stall;

  logic [1:0][REG_W-1:0] rs_id;
  logic [1:0]            use_id;
  logic [1:0][1:0]       fwd;

  // Load in EX feeding an ID read that cannot be forwarded in time.
  // Store data (rs2) is exempt: it is picked up later in MEM.
  always_comb begin
    stall = 1'b0;
    if (ex_q.op == OPT_LOAD && ex_q.rd != '0) begin
      if (rs1use_ID && rs1_ID == ex_q.rd) stall = 1'b1;
      if (rs2use_ID && rs2_ID == ex_q.rd && hazard_optype_ID != OPT_STORE) stall = 1'b1;
    end
  end

  // Shadow pipeline: a stall injects a bubble into EX, MEM/WB always advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_rd <= '0;
      wb_op <= OPT_OTHER;
    end else begin
      wb_rd <= mem_q.rd;
      wb_op <= mem_q.op;
      mem_q <= ex_q;
      if (stall) ex_q <= '0;
      else       ex_q <= '{rd: rd_ID, op: hazard_optype_ID, rs2: rs2_ID};
    end
  end

  // Stall outranks branch: a stalled branch's operands are not valid yet.
  always_comb begin
    PC_EN_IF     = 1'b1;
    reg_FD_EN    = 1'b1;
    reg_FD_flush = 1'b0;
    reg_DE_flush = 1'b0;
    if (stall) begin
      PC_EN_IF     = 1'b0;
      reg_FD_EN    = 1'b0;
      reg_DE_flush = 1'b1;
    end else if (Branch_ID) begin
      reg_FD_flush = 1'b1;
    end
  end

  assign rs_id  = {rs2_ID, rs1_ID};
  assign use_id = {rs2use_ID, rs1use_ID};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    hazard_fwd_sel #(.REG_W(REG_W)) u_sel (
      .rs_use (use_id[g]),
      .rs     (rs_id[g]),
      .ex_rd  (ex_q.rd),
      .ex_op  (ex_q.op),
      .mem_rd (mem_q.rd),
      .mem_op (mem_q.op),
      .sel    (fwd[g])
    );
  end

  assign forward_ctrl_A = fwd[0];
  assign forward_ctrl_B = fwd[1];

  // Store in MEM whose data register is being loaded by the WB slot.
  assign forward_ctrl_ls = (mem_q.op == OPT_STORE) && (wb_op == OPT_LOAD) &&
                           (wb_rd == mem_q.rs2) && (mem_q.rs2 != '0);

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one task per scenario, inline checks.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_ID, rs2_ID, rd_ID;
  logic       rs1use_ID, rs2use_ID;
  logic [1:0] hazard_optype_ID;
  logic       Branch_ID;
  logic       PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush;
  logic [1:0] forward_ctrl_A, forward_ctrl_B;
  logic       forward_ctrl_ls;

  int checks = 0;
  int failures = 0;
  logic [3:0] ctl;

  assign ctl = {PC_EN_IF, reg_FD_EN, reg_FD_flush, reg_DE_flush};

  localparam logic [3:0] CTL_RUN   = 4'b1100;
  localparam logic [3:0] CTL_STALL = 4'b0001;
  localparam logic [3:0] CTL_BR    = 4'b1110;

  hazard_unit #(.REG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .hazard_optype_ID(hazard_optype_ID), .Branch_ID(Branch_ID),
    .PC_EN_IF(PC_EN_IF), .reg_FD_EN(reg_FD_EN),
    .reg_FD_flush(reg_FD_flush), .reg_DE_flush(reg_DE_flush),
    .forward_ctrl_A(forward_ctrl_A), .forward_ctrl_B(forward_ctrl_B),
    .forward_ctrl_ls(forward_ctrl_ls)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic [1:0] op, input logic br);
    rs1_ID = r1; rs2_ID = r2; rd_ID = rd;
    rs1use_ID = u1; rs2use_ID = u2; hazard_optype_ID = op; Branch_ID = br;
    #1;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic nops;
    set_id(0, 0, 0, 0, 0, 2'b00, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_id(5, 6, 7, 1, 1, 2'b10, 1'b0);
    tick();
    checks++;
    if (ctl !== CTL_RUN) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, CTL_RUN); end
    checks++;
    if ({forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls} !== 5'b0) begin
      failures++; $display("FAIL reset_fwd got=%b exp=00000", {forward_ctrl_A, forward_ctrl_B, forward_ctrl_ls});
    end
    set_id(0, 0, 0, 0, 0, 2'b00, 0);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_use;
    set_id(1, 0, 5, 1, 0, 2'b10, 0);   // lw x5
    tick();
    set_id(5, 6, 7, 1, 1, 2'b01, 0);   // add x7, x5, x6
    checks++;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL lu_stall got=%b exp=%b", ctl, CTL_STALL); end
    tick();
    checks++;
    if (ctl !== CTL_RUN) begin failures++; $display("FAIL lu_release got=%b exp=%b", ctl, CTL_RUN); end
    checks++;
    if (forward_ctrl_A !== 2'b11) begin failures++; $display("FAIL lu_fwdA got=%b exp=11", forward_ctrl_A); end
    checks++;
    if (forward_ctrl_B !== 2'b00) begin failures++; $display("FAIL lu_fwdB got=%b exp=00", forward_ctrl_B); end
    nops();
  endtask

  task automatic test_alu_chain;
    set_id(1, 0, 3, 1, 0, 2'b01, 0);   // addi x3
    tick();
    set_id(3, 3, 9, 1, 1, 2'b01, 0);   // add x9, x3, x3 (observed only)
    checks++;
    if ({forward_ctrl_A, forward_ctrl_B} !== 4'b0101) begin
      failures++; $display("FAIL alu_ex got=%b exp=0101", {forward_ctrl_A, forward_ctrl_B});
    end
    set_id(0, 0, 0, 0, 0, 2'b00, 0);   // nop goes down instead
    tick();
    set_id(3, 3, 9, 1, 1, 2'b01, 0);
    checks++;
    if ({forward_ctrl_A, forward_ctrl_B} !== 4'b1010) begin
      failures++; $display("FAIL alu_mem got=%b exp=1010", {forward_ctrl_A, forward_ctrl_B});
    end
    nops();
  endtask

  task automatic test_priority;
    set_id(1, 0, 4, 1, 0, 2'b01, 0);
    tick();
    set_id(4, 0, 4, 1, 0, 2'b01, 0);
    tick();                            // EX and MEM both write x4
    set_id(4, 4, 10, 1, 1, 2'b01, 0);
    checks++;
    if ({forward_ctrl_A, forward_ctrl_B} !== 4'b0101) begin
      failures++; $display("FAIL prio_ex got=%b exp=0101", {forward_ctrl_A, forward_ctrl_B});
    end
    set_id(0, 4, 10, 0, 0, 2'b01, 0);
    checks++;
    if ({forward_ctrl_A, forward_ctrl_B} !== 4'b0000) begin
      failures++; $display("FAIL prio_nouse got=%b exp=0000", {forward_ctrl_A, forward_ctrl_B});
    end
    nops();
    // load to x0 is not a writer: no stall, no forward
    set_id(1, 0, 0, 1, 0, 2'b10, 0);
    tick();
    set_id(0, 0, 11, 1, 1, 2'b01, 0);
    checks++;
    if ({ctl, forward_ctrl_A, forward_ctrl_B} !== {CTL_RUN, 4'b0000}) begin
      failures++; $display("FAIL x0_load got=%b exp=%b", {ctl, forward_ctrl_A, forward_ctrl_B}, {CTL_RUN, 4'b0000});
    end
    nops();
  endtask

  task automatic test_load_store;
    set_id(1, 0, 6, 1, 0, 2'b10, 0);   // lw x6
    tick();
    set_id(1, 6, 12, 0, 1, 2'b01, 0);  // non-store reading x6 via rs2 must stall
    checks++;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL ls_rs2_stall got=%b exp=%b", ctl, CTL_STALL); end
    set_id(7, 6, 5, 1, 1, 2'b11, 0);   // sw x6, imm(x7); rd field = 5
    checks++;
    if ({ctl, forward_ctrl_B} !== {CTL_RUN, 2'b00}) begin
      failures++; $display("FAIL ls_nostall got=%b exp=%b", {ctl, forward_ctrl_B}, {CTL_RUN, 2'b00});
    end
    tick();
    set_id(0, 0, 0, 0, 0, 2'b00, 0);
    checks++;
    if (forward_ctrl_ls !== 1'b0) begin failures++; $display("FAIL ls_early got=%b exp=0", forward_ctrl_ls); end
    tick();
    set_id(5, 0, 13, 1, 0, 2'b01, 0);  // store in MEM with rd=5 is not a writer
    checks++;
    if (forward_ctrl_ls !== 1'b1) begin failures++; $display("FAIL ls_fwd got=%b exp=1", forward_ctrl_ls); end
    checks++;
    if (forward_ctrl_A !== 2'b00) begin failures++; $display("FAIL store_nowrite got=%b exp=00", forward_ctrl_A); end
    tick();
    checks++;
    if (forward_ctrl_ls !== 1'b0) begin failures++; $display("FAIL ls_after got=%b exp=0", forward_ctrl_ls); end
    nops();
  endtask

  task automatic test_branch_stall;
    set_id(1, 0, 8, 1, 0, 2'b10, 0);   // lw x8
    tick();
    set_id(8, 9, 0, 1, 1, 2'b00, 1);   // beq x8, x9 taken
    checks++;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL br_stall got=%b exp=%b", ctl, CTL_STALL); end
    tick();
    checks++;
    if (ctl !== CTL_BR) begin failures++; $display("FAIL br_flush got=%b exp=%b", ctl, CTL_BR); end
    checks++;
    if (forward_ctrl_A !== 2'b11) begin failures++; $display("FAIL br_fwdA got=%b exp=11", forward_ctrl_A); end
    nops();
  endtask

  task automatic test_reset_mid_stall;
    set_id(1, 0, 5, 1, 0, 2'b10, 0);
    tick();
    set_id(5, 0, 7, 1, 0, 2'b01, 0);
    checks++;
    if (ctl !== CTL_STALL) begin failures++; $display("FAIL rms_pre got=%b exp=%b", ctl, CTL_STALL); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({ctl, forward_ctrl_A} !== {CTL_RUN, 2'b00}) begin
      failures++; $display("FAIL rms_async got=%b exp=%b", {ctl, forward_ctrl_A}, {CTL_RUN, 2'b00});
    end
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if ({ctl, forward_ctrl_A} !== {CTL_RUN, 2'b00}) begin
      failures++; $display("FAIL rms_after got=%b exp=%b", {ctl, forward_ctrl_A}, {CTL_RUN, 2'b00});
    end
    nops();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_alu_chain();
    test_priority();
    test_load_store();
    test_branch_stall();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
